pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall and multicycle-sequencing controller for the 5-stage openMIPS core. It merges stall requests from ID (load-use / operand hazard) and EX (multicycle ops) into the per-stage `stall` vector consumed by pc_reg and the pipeline registers. It owns the start/ready handshake with the iterative divider, including timeout and flush-abort. It also keeps a saturating stall-cycle counter for performance bring-up.

## Interface
Parameters:
- `DIV_TIMEOUT`, 40: maximum BUSY cycles allowed before the divider is declared hung.
- `CNT_W`, 6: width of the BUSY cycle counter; must satisfy 2^CNT_W > DIV_TIMEOUT.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stallreq_from_id`  in  1  ID stage hazard stall request.
- `stallreq_from_ex`  in  1  EX stage non-divide multicycle stall request.
- `div_req`  in  1  EX holds a divide instruction; held high until it leaves EX.
- `div_ready`  in  1  divider result available; one-cycle pulse.
- `flush`  in  1  exception/pipeline flush; highest priority.
- `stall`  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- `div_start`  out  1  registered one-cycle start pulse to divider.
- `div_annul`  out  1  registered one-cycle abort pulse to divider.
- `div_done`  out  1  registered; high for the single DONE cycle (EX latches result).
- `div_timeout`  out  1  sticky error flag; cleared only by reset.
- `stall_cycles`  out  32  count of cycles with `stall[0]`=1, saturating at 32'hFFFFFFFF.

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- IDLE: `div_req`=1 and `flush`=0 -> START.
- START: `div_start`=1 for this cycle only; counter cleared; `div_ready` ignored; next BUSY.
- BUSY: counter increments each cycle.
  - `div_ready`=1 -> DONE.
  - Else counter == DIV_TIMEOUT-1 -> DONE and set `div_timeout`.
- DONE: `div_done`=1; next IDLE unconditionally.
- Flush in START or BUSY -> IDLE, `div_annul`=1 next cycle. Flush in DONE -> IDLE, no annul. Flush in IDLE is ignored by the FSM.
- `stall` is combinational from state and request inputs:
  - `flush`=1 -> 6'b000000.
  - Else divide stall active (`div_req`=1 and state != DONE), or `stallreq_from_ex` -> 6'b001111.
  - Else `stallreq_from_id` -> 6'b000111.
  - Else 6'b000000.
  - EX priority over ID.
- `stall_cycles` increments when `stall[0]`=1 and it is below max.

## Timing
- Reset values: state IDLE, counter 0, `div_start`/`div_annul`/`div_done`/`div_timeout` all 0, `stall_cycles` 0. `stall` is 0 when inputs are low.
- `div_req` rising in IDLE at cycle t:
  - `stall`=6'b001111 in cycle t (combinational).
  - `div_start`=1 at t+1; BUSY from t+2.
- `div_ready` at cycle k (BUSY):
  - DONE and `div_done`=1 at k+1.
  - `stall` drops to 0 in cycle k+1 so EX advances on that edge.
- Back-to-back divides: a new `div_req` seen in the IDLE cycle after DONE restarts the sequence with no extra bubble.
- Timeout: with no ready, exactly DIV_TIMEOUT BUSY cycles, then DONE with `div_timeout`=1 in the DONE cycle.
- Reset asserted mid-sequence: immediate IDLE, all outputs cleared, no annul pulse.

## Test plan
- Reset low 10 cycles, then high with all inputs 0 -> `stall`=6'b000000, all flags 0, `stall_cycles`=0.
- `stallreq_from_id`=1 for 3 cycles -> `stall`=6'b000111 for those cycles; `stall_cycles`=3.
- `div_req` at t0, `div_ready` pulse at t0+34:
  - `div_start` pulses at t0+1 only.
  - `stall`=6'b001111 for t0..t0+34.
  - `div_done` at t0+35, `stall`=0 at t0+35.
  - `stall_cycles`=35.
- `div_req` held, no `div_ready`, DIV_TIMEOUT=40 -> DONE at t0+42, `div_timeout`=1 and stays 1 after `div_req` drops.
- `flush` at t0+10 during BUSY -> `stall`=0 that cycle, `div_annul`=1 at t0+11, state IDLE, no `div_done`.
- `stallreq_from_id`=1 and `div_req`=1 together -> `stall`=6'b001111; then `div_req`=1 with `flush`=1 in IDLE -> stays IDLE, `div_start` never pulses.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central stall merge and divider sequencing for the 5-stage core.
// Merges ID/EX stall requests into the per-stage stall vector, runs the
// start/ready handshake with the iterative divider (timeout and flush-abort),
// and counts stalled cycles for performance bring-up.
module pipeline_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 40,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        div_req,
    input  logic        div_ready,
    input  logic        flush,
    output logic [5:0]  stall,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_done,
    output logic        div_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Last BUSY count value before the divider is declared hung.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             annul_d;
    logic             timeout_set;
    logic             div_stall;

    // Next-state decode for the divider handshake; flush beats everything.
    always_comb begin
        state_d     = state_q;
        annul_d     = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (div_req && !flush) state_d = START;
            end
            START: begin
                if (flush) begin
                    state_d = IDLE;
                    annul_d = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    annul_d = 1'b1;
                end else if (div_ready) begin
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = DONE;
                    timeout_set = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // BUSY cycle counter: cleared in START, counts while BUSY.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM state, counter and registered handshake pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_start   <= 1'b0;
            div_annul   <= 1'b0;
            div_done    <= 1'b0;
            div_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_start   <= (state_d == START);
            div_done    <= (state_d == DONE);
            div_annul   <= annul_d;
            div_timeout <= div_timeout | timeout_set;
        end
    end

    // Divide holds the pipe until the DONE cycle, when EX latches the result
    // and must advance.
    assign div_stall = div_req && (state_q != DONE);

    // Stall vector merge: flush clears, EX (incl. divide) outranks ID.
    always_comb begin
        stall = STALL_NONE;
        if (flush) begin
            stall = STALL_NONE;
        end else if (div_stall || stallreq_from_ex) begin
            stall = STALL_EX;
        end else if (stallreq_from_id) begin
            stall = STALL_ID;
        end
    end

    // Saturating count of cycles with the PC stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
